// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline types, hazard FSM state/cause enums and the cause-priority helper.
package rv32i_types;
  typedef enum logic {RUN, SQUASH} hazard_state_t;
  typedef enum logic [2:0] {HZ_NONE, HZ_DSTALL, HZ_REDIR, HZ_LUSE, HZ_ISTALL} hazard_cause_t;
  function automatic hazard_cause_t hz_cause(input hazard_state_t s, input logic d, input logic b,
                                             input logic l, input logic i);
    if (s == SQUASH) return d ? HZ_DSTALL : HZ_REDIR;
    return d ? HZ_DSTALL : b ? HZ_REDIR : l ? HZ_LUSE : i ? HZ_ISTALL : HZ_NONE;
  endfunction
endpackage

// File: rtl/hazard_perf_ctr.sv
// hazard_perf_ctr: one saturating event counter, holds at all-ones.
module hazard_perf_ctr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with post-redirect fetch squash.
// Define PIPE_PERF_CTR_EN to add the four saturating hazard perf counters.
module pipeline_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int REG_ADDR_W = 5
`ifdef PIPE_PERF_CTR_EN
  , parameter int CTR_WIDTH = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_resp,
  input  logic                  dmem_resp,
  input  logic                  mem_access,
  input  logic                  br_taken,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  output logic                  load_pc,
  output logic                  load_if_id,
  output logic                  load_id_ex,
  output logic                  load_ex_mem,
  output logic                  load_mem_wb,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  squash_active
`ifdef PIPE_PERF_CTR_EN
  , output logic [CTR_WIDTH-1:0] perf_dstall
  , output logic [CTR_WIDTH-1:0] perf_redir
  , output logic [CTR_WIDTH-1:0] perf_luse
  , output logic [CTR_WIDTH-1:0] perf_istall
`endif
);
  hazard_state_t r_state, w_next;
  hazard_cause_t w_cause;
  logic w_dstall, w_istall, w_luse;
  assign w_dstall = mem_access & ~dmem_resp;
  assign w_istall = ~imem_resp;
  assign w_luse   = idex_mem_read & (idex_rd != '0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2);
  assign w_cause  = hz_cause(r_state, w_dstall, br_taken, w_luse, w_istall);
  assign squash_active = rst_n & (r_state == SQUASH);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= RUN;
    else r_state <= w_next;
  always_comb begin
    w_next      = r_state;
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (rst_n && r_state == RUN) begin
      load_pc     = w_cause inside {HZ_NONE, HZ_REDIR};
      load_if_id  = w_cause inside {HZ_NONE, HZ_REDIR};
      load_id_ex  = w_cause != HZ_DSTALL;
      load_ex_mem = w_cause != HZ_DSTALL;
      load_mem_wb = w_cause != HZ_DSTALL;
      flush_if_id = w_cause == HZ_REDIR;
      flush_id_ex = w_cause inside {HZ_REDIR, HZ_LUSE, HZ_ISTALL};
      w_next      = (w_cause == HZ_REDIR && w_istall) ? SQUASH : RUN;
    end else if (rst_n) begin
      load_if_id  = 1'b1;
      flush_if_id = 1'b1;
      load_id_ex  = ~w_dstall;
      flush_id_ex = 1'b1;
      load_ex_mem = ~w_dstall;
      load_mem_wb = ~w_dstall;
      w_next      = imem_resp ? RUN : SQUASH;
    end
  end
  // EX only holds bubbles while a stale fetch is outstanding, so no redirect can resolve here
  a_no_redir_in_squash: assert property (@(posedge clk) disable iff (!rst_n) r_state == SQUASH |-> !br_taken);
`ifdef PIPE_PERF_CTR_EN
  hazard_perf_ctr #(.W(CTR_WIDTH)) u_ctr_dstall (.clk(clk), .rst_n(rst_n), .i_inc(w_cause == HZ_DSTALL), .o_cnt(perf_dstall));
  hazard_perf_ctr #(.W(CTR_WIDTH)) u_ctr_redir  (.clk(clk), .rst_n(rst_n), .i_inc(w_cause == HZ_REDIR),  .o_cnt(perf_redir));
  hazard_perf_ctr #(.W(CTR_WIDTH)) u_ctr_luse   (.clk(clk), .rst_n(rst_n), .i_inc(w_cause == HZ_LUSE),   .o_cnt(perf_luse));
  hazard_perf_ctr #(.W(CTR_WIDTH)) u_ctr_istall (.clk(clk), .rst_n(rst_n), .i_inc(w_cause == HZ_ISTALL), .o_cnt(perf_istall));
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors against hand-computed load/flush/squash patterns.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic imem_resp, dmem_resp, mem_access, br_taken, idex_mem_read;
  logic [4:0] idex_rd, ifid_rs1, ifid_rs2;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, squash_active;
  int n_cmp = 0, n_bad = 0;
`ifdef PIPE_PERF_CTR_EN
  logic [3:0] perf_dstall, perf_redir, perf_luse, perf_istall;
`endif
  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, squash_active}
  localparam logic [7:0] ALL = 8'hF8, FRZ = 8'h00, RDR = 8'hFE, BUB = 8'h3A, SQ = 8'h7F, SQD = 8'h47;
  wire [7:0] w_out = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex, squash_active};
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5)
`ifdef PIPE_PERF_CTR_EN
    , .CTR_WIDTH(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem_resp(imem_resp), .dmem_resp(dmem_resp), .mem_access(mem_access),
    .br_taken(br_taken), .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2), .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .squash_active(squash_active)
`ifdef PIPE_PERF_CTR_EN
    , .perf_dstall(perf_dstall), .perf_redir(perf_redir), .perf_luse(perf_luse), .perf_istall(perf_istall)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    imem_resp = 1; dmem_resp = 1; mem_access = 0; br_taken = 0;
    idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
  endtask
  task automatic cyc(input string tag, input logic [7:0] exp);
    #1 check(tag, {24'h0, w_out}, {24'h0, exp});
    @(negedge clk);
  endtask
  initial begin
    idle();
    #1 check("reset_outputs", {24'h0, w_out}, 32'h0);
    @(negedge clk);
    rst_n = 1;
    cyc("run_idle", ALL);
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs2 = 1;
    cyc("luse_rs1", BUB);
    idex_mem_read = 0;
    cyc("luse_after", ALL);
    idex_mem_read = 1; idex_rd = 7; ifid_rs1 = 2; ifid_rs2 = 7;
    cyc("luse_rs2", BUB);
    idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 3;
    cyc("luse_x0_exempt", ALL);
    idle(); mem_access = 1; dmem_resp = 0; br_taken = 1;
    for (int i = 0; i < 4; i++) cyc($sformatf("dstall_br_%0d", i), FRZ);
    dmem_resp = 1;
    cyc("deferred_redirect", RDR);
    idle();
    cyc("after_redirect", ALL);
    br_taken = 1; idex_mem_read = 1; idex_rd = 4; ifid_rs1 = 4;
    cyc("br_beats_luse", RDR);
    br_taken = 0; imem_resp = 0;
    cyc("luse_with_istall", BUB);
    idle(); imem_resp = 0;
    cyc("istall_only", BUB);
    mem_access = 1; dmem_resp = 0; idex_mem_read = 1; idex_rd = 9; ifid_rs2 = 9;
    cyc("dstall_beats_luse", FRZ);
    idle(); br_taken = 1; imem_resp = 0;
    cyc("redirect_into_squash", RDR);
    br_taken = 0;
    cyc("squash_wait", SQ);
    mem_access = 1; dmem_resp = 0;
    cyc("squash_dstall", SQD);
    idle();
    cyc("squash_resp", SQ);
    cyc("squash_exit_run", ALL);
    br_taken = 1; imem_resp = 0;
    cyc("redirect_again", RDR);
    br_taken = 0;
    #2 rst_n = 0;
    #1 check("async_reset_outputs", {24'h0, w_out}, 32'h0);
    @(negedge clk);
    rst_n = 1; imem_resp = 1;
    cyc("run_after_reset", ALL);
`ifdef PIPE_PERF_CTR_EN
    rst_n = 0; #1 rst_n = 1;
    mem_access = 1; dmem_resp = 0;
    repeat (20) @(negedge clk);
    #1 check("perf_dstall_sat", {28'h0, perf_dstall}, 32'd15);
    check("perf_redir_zero", {28'h0, perf_redir}, 32'd0);
    check("perf_luse_zero", {28'h0, perf_luse}, 32'd0);
    check("perf_istall_zero", {28'h0, perf_istall}, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
